capture_reader: RTL and testbench

//  Drains the capture memory filled by the sampler, unrolling its circular buffer
//  so the oldest pre-trigger sample comes out first. Sits between the capture RAM

---
 rtl/capture_reader.sv | 153 +++++++++++++++
 tb/tb_capture_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_reader.sv
// Capture memory readout: unrolls the sampler's circular buffer, oldest
// pre-trigger sample first, onto a valid/ready stream.
module capture_reader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int PRE_SAMPLES = 2**(ADDR_W-1)
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              activate,
  input  logic              abort,
  input  logic [ADDR_W-1:0] trig_addr,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                done_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W:0]     rd_cnt_r;
  logic [ADDR_W:0]     beat_r;
  logic                rd_vld_r;
  logic [DATA_W-1:0]   fifo_r [2];
  logic                wr_ptr_r;
  logic                rd_ptr_r;
  logic [1:0]          count_r;

  logic [ADDR_W-1:0]   start_s;
  logic                valid_s;
  logic                pop_s;
  logic                credit_ok_s;
  logic                mem_re_s;
  logic                abort_s;

  assign start_s  = trig_addr - PRE_OFS;
  assign valid_s  = (count_r != 2'd0);
  assign pop_s    = valid_s & out_ready;
  assign abort_s  = abort & (state_r != IDLE);
  // Head is popped this cycle, so a read may issue when the FIFO is full but draining.
  assign credit_ok_s = (({1'b0, count_r} + {2'b00, rd_vld_r} - {2'b00, pop_s}) < 3'd2);

  // State register plus registered status outputs derived from the next state
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == DONE);
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic; abort beats activate and any progress
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (activate && !abort) state_nxt_s = READ;
        else                    state_nxt_s = IDLE;
      end
      READ: begin
        if (abort)                                  state_nxt_s = IDLE;
        else if (mem_re_s && (rd_cnt_r == LAST_IDX)) state_nxt_s = DRAIN;
        else                                        state_nxt_s = READ;
      end
      DRAIN: begin
        if (abort)                                state_nxt_s = IDLE;
        else if (pop_s && (beat_r == LAST_IDX))   state_nxt_s = DONE;
        else                                      state_nxt_s = DRAIN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read issue: only while reading and while the FIFO credit allows it
  always_comb begin
    mem_re_s = 1'b0;
    if ((state_r == READ) && credit_ok_s) mem_re_s = 1'b1;
    else                                  mem_re_s = 1'b0;
  end

  // Read address/counters, read-return tracking and the 2-entry output FIFO
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      addr_r    <= '0;
      rd_cnt_r  <= '0;
      beat_r    <= '0;
      rd_vld_r  <= 1'b0;
      fifo_r[0] <= '0;
      fifo_r[1] <= '0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
    end else if (abort_s) begin
      rd_vld_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      rd_vld_r <= mem_re_s;
      if ((state_r == IDLE) && activate && !abort) begin
        addr_r   <= start_s;
        rd_cnt_r <= '0;
        beat_r   <= '0;
      end else if (mem_re_s) begin
        addr_r   <= addr_r + ADDR_ONE;
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end
      if (rd_vld_r) begin
        fifo_r[wr_ptr_r] <= mem_data;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
        beat_r   <= beat_r + CNT_ONE;
      end
      count_r <= count_r + {1'b0, rd_vld_r} - {1'b0, pop_s};
    end
  end

  assign done      = done_r;
  assign busy      = busy_r;
  assign mem_addr  = addr_r;
  assign mem_re    = mem_re_s;
  assign out_data  = fifo_r[rd_ptr_r];
  assign out_valid = valid_s;
  assign out_last  = valid_s & (beat_r == LAST_IDX);

endmodule

// File: tb/tb_capture_reader.sv
// Scoreboard bench for capture_reader: directed readouts against a RAM model
// holding mem[i] = i; a forked monitor pops expected beats on each handshake.
module tb_capture_reader;

  logic       clk_50mhz = 1'b0;
  logic       reset     = 1'b0;
  logic       activate  = 1'b0;
  logic       abort     = 1'b0;
  logic [7:0] trig_addr = 8'h00;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic [7:0] mem_data  = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  int         checks     = 0;
  int         errors     = 0;
  int         beat_no    = 0;
  int         cyc        = 0;
  int         first_cyc  = 0;
  int         last_cyc   = 0;
  int         done_cnt   = 0;
  bit         rand_ready = 1'b0;
  logic [8:0] exp_q [$];

  capture_reader #(.ADDR_W(8), .DATA_W(8), .PRE_SAMPLES(128)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .activate  (activate),
    .abort     (abort),
    .trig_addr (trig_addr),
    .done      (done),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // RAM model with one cycle read latency, content mem[i] = i
  always @(posedge clk_50mhz) begin
    if (mem_re) mem_data <= mem_addr;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    bit         prev_stall = 1'b0;
    bit         prev_exc   = 1'b0;
    bit         prev_done  = 1'b0;
    bit         exp_done   = 1'b0;
    logic [7:0] prev_d     = 8'h00;
    logic       prev_l     = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk_50mhz);
      cyc++;
      if (exp_done) begin
        chk("done_after_last", int'(done), 1);
        exp_done = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", int'(prev_done), 0);
      end
      if (prev_stall && !prev_exc) begin
        chk("stall_hold_valid", int'(out_valid), 1);
        chk("stall_hold_data", int'(out_data), int'(prev_d));
        chk("stall_hold_last", int'(out_last), int'(prev_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", int'(out_data), int'(e[7:0]));
          chk("beat_last", int'(out_last), int'(e[8]));
          if (beat_no == 0) first_cyc = cyc;
          beat_no++;
          if (e[8]) begin
            last_cyc = cyc;
            exp_done = 1'b1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_l     = out_last;
      prev_exc   = abort || !reset;
      prev_done  = done;
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk_50mhz);
      #4;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic load_expected(input logic [7:0] trig);
    logic [7:0] s;
    logic [7:0] v;
    s = trig - 8'h80;
    for (int i = 0; i < 256; i++) begin
      v = s + 8'(i);
      exp_q.push_back({(i == 255), v});
    end
  endtask

  task automatic start_readout(input logic [7:0] trig, input bit lat, input bit hold);
    logic [7:0] s;
    s = trig - 8'h80;
    @(posedge clk_50mhz);
    #4;
    trig_addr = trig;
    activate  = 1'b1;
    beat_no   = 0;
    load_expected(trig);
    @(posedge clk_50mhz);
    #4;
    activate  = hold;
    trig_addr = ~trig;
    if (lat) begin
      @(negedge clk_50mhz);
      chk("lat_mem_re_e0", int'(mem_re), 1);
      chk("lat_mem_addr_e0", int'(mem_addr), int'(s));
      chk("lat_busy_e0", int'(busy), 1);
      chk("lat_valid_e0", int'(out_valid), 0);
      @(negedge clk_50mhz);
      chk("lat_valid_e1", int'(out_valid), 0);
      @(negedge clk_50mhz);
      chk("lat_valid_e2", int'(out_valid), 1);
      chk("lat_data_e2", int'(out_data), int'(s));
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_50mhz);
      if (done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mem_re", int'(mem_re), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
  endtask

  initial begin
    int  dn0;
    int  base;
    bit  reached;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    #35;
    check_reset_outputs();
    @(posedge clk_50mhz);
    #4;
    reset = 1'b1;

    // Test 1: wrapped readout, full throughput, single done
    dn0 = done_cnt;
    start_readout(8'h10, 1'b1, 1'b0);
    wait_done(400);
    chk("t1_throughput", last_cyc - first_cyc, 255);
    repeat (2) @(negedge clk_50mhz);
    chk("t1_done_count", done_cnt - dn0, 1);
    chk("t1_idle_busy", int'(busy), 0);

    // Test 2: no-wrap readout with latency checks
    start_readout(8'h80, 1'b1, 1'b0);
    wait_done(400);
    chk("t2_throughput", last_cyc - first_cyc, 255);

    // Test 3: random backpressure
    rand_ready = 1'b1;
    start_readout(8'h10, 1'b0, 1'b0);
    wait_done(3000);
    rand_ready = 1'b0;
    @(posedge clk_50mhz);
    #4;
    out_ready = 1'b1;

    // Test 4: abort after beat 100, then clean readout
    dn0 = done_cnt;
    start_readout(8'h10, 1'b0, 1'b0);
    base    = beat_no;
    reached = 1'b0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge clk_50mhz);
      if (beat_no >= base + 101) reached = 1'b1;
    end
    chk("t4_beats_before_abort", int'(reached), 1);
    @(posedge clk_50mhz);
    #4;
    abort    = 1'b1;
    activate = 1'b1;
    @(posedge clk_50mhz);
    #4;
    abort    = 1'b0;
    activate = 1'b0;
    exp_q.delete();
    @(negedge clk_50mhz);
    chk("t4_abort_valid", int'(out_valid), 0);
    chk("t4_abort_mem_re", int'(mem_re), 0);
    chk("t4_abort_busy", int'(busy), 0);
    repeat (4) @(negedge clk_50mhz);
    chk("t4_no_done", done_cnt - dn0, 0);
    chk("t4_still_idle", int'(busy), 0);
    start_readout(8'h80, 1'b1, 1'b0);
    wait_done(400);

    // Test 5: asynchronous reset mid-readout
    start_readout(8'h10, 1'b0, 1'b0);
    repeat (50) @(negedge clk_50mhz);
    #3;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk_50mhz);
    #4;
    reset = 1'b1;
    start_readout(8'h10, 1'b1, 1'b0);
    wait_done(400);

    // Test 6: activate held through readout and the DONE cycle
    dn0 = done_cnt;
    start_readout(8'h10, 1'b0, 1'b1);
    wait_done(400);
    @(posedge clk_50mhz);
    #4;
    activate = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("t6_busy_after", int'(busy), 0);
    chk("t6_done_count", done_cnt - dn0, 1);
    chk("t6_no_extra_beats", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
